lcd_nibble_driver: RTL and testbench

Responder side of the controller→driver command interface in the LCD 1602A path. It accepts one byte per handshake and serialises it onto the LCD 4-bit bus as two nibbles, high nibble first. Each nibble gets RS setup, an E pulse and hold time. After the byte it waits for the command execution time, then returns a one-cycle driver_rdy. It sits between the control FSM (enable, data, RS select) and the LCD pins. The write-only bus (RW=0) and the 4-bit mode are fixed.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_nibble_driver_if.sv | 13 +
 rtl/lcd_delay_counter.sv | 20 ++
 rtl/lcd_nibble_driver.sv | 109 ++++++++++
 tb/tb_lcd_nibble_driver.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD 1602A 4-bit write path.
//   state_e  - one-hot driver FSM states
//   RS_*     - register select values
//   *_DEF    - timing defaults for a 50 MHz clock
//   CMD_*    - LCD command bytes shared with the control block
package lcd_pkg;
  typedef enum logic [8:0] {
    IDLE      = 9'h001,
    SETUP_HI  = 9'h002,
    PULSE_HI  = 9'h004,
    GAP_HI    = 9'h008,
    SETUP_LO  = 9'h010,
    PULSE_LO  = 9'h020,
    EXEC_WAIT = 9'h040,
    DONE      = 9'h080,
    RECOVER   = 9'h100
  } state_e;
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;
  localparam int T_AS_DEF   = 2;
  localparam int T_PW_DEF   = 13;
  localparam int T_GAP_DEF  = 50;
  localparam int T_EXEC_DEF = 2100;
  localparam int CNT_W_DEF  = 12;
  localparam logic [7:0] CMD_SETUP      = 8'h28;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
endpackage

// File: rtl/lcd_nibble_driver_if.sv
// lcd_nibble_driver_if: controller-to-driver command handshake.
//   enable, data_in, rs_in, single_nibble : controller -> driver
//   driver_rdy (1-cycle pulse), busy      : driver -> controller
interface lcd_nibble_driver_if;
  logic       enable;
  logic [7:0] data_in;
  logic       rs_in;
  logic       single_nibble;
  logic       driver_rdy;
  logic       busy;
  modport master (output enable, data_in, rs_in, single_nibble, input driver_rdy, busy);
  modport slave  (input enable, data_in, rs_in, single_nibble, output driver_rdy, busy);
endinterface

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable down-counter that stops at zero.
//   clk, rst (sync, active-low), load/load_val : load a new count
//   zero : registered count is zero
module lcd_delay_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
  assign zero = cnt_q == '0;
endmodule

// File: rtl/lcd_nibble_driver.sv
// lcd_nibble_driver: serialises one byte per handshake onto the LCD 4-bit bus.
//   clk, rst (sync, active-low)
//   cmd    : command handshake (slave side)
//   lcd_rs, lcd_rw (tied 0), lcd_e, lcd_db[3:0] : registered LCD pins (DB7..DB4)
module lcd_nibble_driver
  import lcd_pkg::*;
#(
  parameter int T_AS   = T_AS_DEF,
  parameter int T_PW   = T_PW_DEF,
  parameter int T_GAP  = T_GAP_DEF,
  parameter int T_EXEC = T_EXEC_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_nibble_driver_if.slave   cmd,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic [3:0]           lcd_db
);
  // Counter preloads are count-1: a state exits on the edge where the counter is 0.
  localparam logic [CNT_W-1:0] LD_AS = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_PW = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_GP = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LD_EX = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_GX = CNT_W'(T_GAP + T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_RC = CNT_W'(1);
  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             single_q, single_d;
  logic             rs_q, rs_d;
  logic [3:0]       db_q, db_d;
  logic             e_q, e_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             load, zero, accept;
  logic [CNT_W-1:0] load_val;
  lcd_delay_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .zero(zero)
  );
  // The last RECOVER edge doubles as an IDLE edge so a held enable is
  // accepted exactly three cycles after driver_rdy.
  assign accept = cmd.enable && (state_q == IDLE || (state_q == RECOVER && zero));
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    single_d = single_q;
    rs_d     = rs_q;
    db_d     = db_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      SETUP_HI:  if (zero) begin state_d = PULSE_HI; load = 1'b1; load_val = LD_PW; end
      PULSE_HI:  if (zero) begin state_d = GAP_HI;   load = 1'b1; load_val = LD_GP; end
      GAP_HI:    if (zero) begin
        state_d  = single_q ? EXEC_WAIT : SETUP_LO;
        load     = 1'b1;
        load_val = single_q ? LD_EX : LD_AS;
        db_d     = single_q ? db_q : byte_q[3:0];
      end
      SETUP_LO:  if (zero) begin state_d = PULSE_LO;  load = 1'b1; load_val = LD_PW; end
      PULSE_LO:  if (zero) begin state_d = EXEC_WAIT; load = 1'b1; load_val = LD_GX; end
      EXEC_WAIT: if (zero) state_d = DONE;
      DONE:      begin state_d = RECOVER; load = 1'b1; load_val = LD_RC; end
      RECOVER:   if (zero) state_d = IDLE;
      default:   ;
    endcase
    if (accept) begin
      state_d  = SETUP_HI;
      byte_d   = cmd.data_in;
      rs_d     = cmd.rs_in;
      single_d = cmd.single_nibble;
      db_d     = cmd.data_in[7:4];
      load     = 1'b1;
      load_val = LD_AS;
    end
    e_d    = state_d == PULSE_HI || state_d == PULSE_LO;
    rdy_d  = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      byte_q   <= '0;
      single_q <= 1'b0;
      rs_q     <= 1'b0;
      db_q     <= '0;
      e_q      <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      single_q <= single_d;
      rs_q     <= rs_d;
      db_q     <= db_d;
      e_q      <= e_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end
  assign lcd_rs         = rs_q;
  assign lcd_rw         = 1'b0;
  assign lcd_e          = e_q;
  assign lcd_db         = db_q;
  assign cmd.driver_rdy = rdy_q;
  assign cmd.busy       = busy_q;
endmodule

// File: tb/tb_lcd_nibble_driver.sv
// tb_lcd_nibble_driver: self-checking bench for lcd_nibble_driver (small and default timing).
module tb_lcd_nibble_driver;
  localparam int S_AS = 1, S_PW = 2, S_GAP = 3, S_EX = 5;
  localparam int L_B  = 2*S_AS + 2*S_PW + 2*S_GAP + S_EX;
  localparam int L_N  = S_AS + S_PW + S_GAP + S_EX;
  localparam int D_PW = 13;
  localparam int D_L  = 2*2 + 2*13 + 2*50 + 2100;
  typedef struct {
    logic [7:0] d;
    logic       rs;
    logic       sn;
    logic [3:0] hi;
    logic [3:0] lo;
    int         lat;
  } vec_t;
  typedef struct {
    logic [3:0] db;
    logic       rs;
  } nib_t;
  logic clk = 1'b0, rst_s = 1'b0, rst_d = 1'b0;
  always #5 clk = ~clk;
  lcd_nibble_driver_if s_if ();
  lcd_nibble_driver_if d_if ();
  logic s_rs, s_rw, s_e, d_rs, d_rw, d_e;
  logic [3:0] s_db, d_db;
  lcd_nibble_driver #(.T_AS(S_AS), .T_PW(S_PW), .T_GAP(S_GAP), .T_EXEC(S_EX), .CNT_W(12)) u_s (
    .clk(clk), .rst(rst_s), .cmd(s_if), .lcd_rs(s_rs), .lcd_rw(s_rw), .lcd_e(s_e), .lcd_db(s_db)
  );
  lcd_nibble_driver u_d (
    .clk(clk), .rst(rst_d), .cmd(d_if), .lcd_rs(d_rs), .lcd_rw(d_rw), .lcd_e(d_e), .lcd_db(d_db)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  nib_t sb[$];
  int rise_q[$];
  int rise_cyc = 0, rdy_cnt = 0, rdy_cyc = 0;
  logic pe = 1'b0, pr = 1'b0, rise_rs = 1'b0;
  logic [3:0] rise_db = '0;
  vec_t vecs[5];
  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Monitor for the small-timing instance: scoreboard of nibbles at each E rise.
  always @(negedge clk) begin
    if (s_e && !pe) begin
      rise_q.push_back(cyc);
      rise_cyc = cyc;
      rise_db  = s_db;
      rise_rs  = s_rs;
      check("rw_at_e", int'(s_rw), 0);
      if (sb.size() == 0) check("unexpected_e_pulse", 1, 0);
      else begin
        nib_t n;
        n = sb.pop_front();
        check("nibble_db", int'(s_db), int'(n.db));
        check("nibble_rs", int'(s_rs), int'(n.rs));
      end
    end else if (s_e && pe) begin
      check("db_stable_e_high", int'(s_db), int'(rise_db));
      check("rs_stable_e_high", int'(s_rs), int'(rise_rs));
    end
    if (!s_e && pe && rst_s) check("e_width", cyc - rise_cyc, S_PW);
    if (s_if.driver_rdy) begin
      check("rdy_one_cycle", int'(pr), 0);
      rdy_cnt++;
      rdy_cyc = cyc;
    end
    pe = s_e;
    pr = s_if.driver_rdy;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_rdy(input int n0, input int bound);
    int k = 0;
    while (rdy_cnt == n0 && k < bound) begin
      step();
      k++;
    end
    check("rdy_seen", int'(rdy_cnt > n0), 1);
  endtask
  task automatic run_vec(input vec_t v, input bit mess);
    int a, n0, k;
    nib_t n;
    rise_q.delete();
    n0 = rdy_cnt;
    n.db = v.hi; n.rs = v.rs; sb.push_back(n);
    if (!v.sn) begin n.db = v.lo; sb.push_back(n); end
    s_if.enable = 1'b1;
    s_if.data_in = v.d;
    s_if.rs_in = v.rs;
    s_if.single_nibble = v.sn;
    a = cyc + 1;
    step();
    check("busy_after_accept", int'(s_if.busy), 1);
    if (mess) begin
      k = 0;
      while (!s_e && k < 20) begin step(); k++; end
      check("reached_pulse_hi", int'(s_e), 1);
      s_if.data_in = ~v.d;
      s_if.rs_in = ~v.rs;
      s_if.single_nibble = ~v.sn;
    end
    s_if.enable = 1'b0;
    wait_rdy(n0, 100);
    check("latency", rdy_cyc - a, v.lat);
    check("e_pulses", rise_q.size(), v.sn ? 1 : 2);
    if (rise_q.size() > 0) check("rs_setup", rise_q[0] - a, S_AS);
    if (rise_q.size() > 1) check("pulse_spacing", rise_q[1] - rise_q[0], S_PW + S_GAP + S_AS);
    repeat (6) step();
    check("rdy_once", rdy_cnt - n0, 1);
    check("sb_empty", sb.size(), 0);
    sb.delete();
    check("idle_busy", int'(s_if.busy), 0);
  endtask
  initial begin
    int a, n0, r, k, rises, w1, first_rise, d_rdy;
    logic dpe, done;
    logic [3:0] dnib[2];
    nib_t n;
    vec_t mv;
    vecs[0] = '{8'h28, 1'b0, 1'b0, 4'h2, 4'h8, L_B};
    vecs[1] = '{8'h30, 1'b0, 1'b1, 4'h3, 4'h0, L_N};
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 4'hA, 4'h5, L_B};
    vecs[3] = '{8'h0F, 1'b1, 1'b1, 4'h0, 4'h0, L_N};
    vecs[4] = '{8'hC3, 1'b0, 1'b0, 4'hC, 4'h3, L_B};
    s_if.enable = 1'b1; s_if.data_in = 8'hFF; s_if.rs_in = 1'b1; s_if.single_nibble = 1'b0;
    d_if.enable = 1'b0; d_if.data_in = 8'h00; d_if.rs_in = 1'b0; d_if.single_nibble = 1'b0;
    repeat (3) step();
    check("rst_rs", int'(s_rs), 0);
    check("rst_rw", int'(s_rw), 0);
    check("rst_e", int'(s_e), 0);
    check("rst_db", int'(s_db), 0);
    check("rst_rdy", int'(s_if.driver_rdy), 0);
    check("rst_busy", int'(s_if.busy), 0);
    s_if.enable = 1'b0;
    rst_s = 1'b1;
    repeat (4) step();
    check("quiet_e", int'(s_e), 0);
    check("quiet_db", int'(s_db), 0);
    check("quiet_rdy", int'(s_if.driver_rdy), 0);
    check("quiet_busy", int'(s_if.busy), 0);
    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);
    mv = '{8'h5A, 1'b0, 1'b0, 4'h5, 4'hA, L_B};
    run_vec(mv, 1'b1);
    // Back-to-back with enable held high.
    rise_q.delete();
    n0 = rdy_cnt;
    n.rs = 1'b1;
    n.db = 4'h4; sb.push_back(n);
    n.db = 4'h1; sb.push_back(n);
    n.db = 4'h4; sb.push_back(n);
    n.db = 4'h2; sb.push_back(n);
    s_if.enable = 1'b1; s_if.data_in = 8'h41; s_if.rs_in = 1'b1; s_if.single_nibble = 1'b0;
    a = cyc + 1;
    step();
    s_if.data_in = 8'h42;
    wait_rdy(n0, 100);
    check("b2b_first_latency", rdy_cyc - a, L_B);
    r = rdy_cyc;
    while (cyc < r + 3) step();
    s_if.enable = 1'b0;
    wait_rdy(n0 + 1, 100);
    check("b2b_second_latency", rdy_cyc - (r + 3), L_B);
    check("b2b_e_pulses", rise_q.size(), 4);
    if (rise_q.size() > 2) check("b2b_accept_gap", rise_q[2] - r, 3 + S_AS);
    repeat (6) step();
    check("b2b_rdy_count", rdy_cnt - n0, 2);
    check("b2b_sb_empty", sb.size(), 0);
    sb.delete();
    // Reset during PULSE_LO.
    rise_q.delete();
    n0 = rdy_cnt;
    n.rs = 1'b0;
    n.db = 4'h9; sb.push_back(n);
    n.db = 4'h6; sb.push_back(n);
    s_if.enable = 1'b1; s_if.data_in = 8'h96; s_if.rs_in = 1'b0;
    step();
    s_if.enable = 1'b0;
    k = 0;
    while (rise_q.size() < 2 && k < 30) begin step(); k++; end
    check("reached_pulse_lo", int'(s_e), 1);
    rst_s = 1'b0;
    step();
    check("abort_e", int'(s_e), 0);
    check("abort_busy", int'(s_if.busy), 0);
    check("abort_db", int'(s_db), 0);
    step();
    rst_s = 1'b1;
    repeat (30) step();
    check("abort_no_rdy", rdy_cnt - n0, 0);
    check("abort_idle", int'(s_if.busy), 0);
    sb.delete();
    // Default timing instance: CLEAR command.
    rst_d = 1'b1;
    step();
    d_if.enable = 1'b1; d_if.data_in = 8'h01; d_if.rs_in = 1'b0;
    a = cyc + 1;
    step();
    d_if.enable = 1'b0;
    rises = 0; w1 = 0; first_rise = 0; d_rdy = 0; dpe = 1'b0; done = 1'b0;
    dnib[0] = 4'hF; dnib[1] = 4'hF;
    for (int j = 0; j < 3000 && !done; j++) begin
      check("default_rw", int'(d_rw), 0);
      if (d_e && !dpe) begin
        if (rises < 2) dnib[rises] = d_db;
        if (rises == 0) first_rise = cyc;
        rises++;
      end
      if (d_e && rises == 1) w1++;
      if (d_if.driver_rdy) begin d_rdy = cyc; done = 1'b1; end
      dpe = d_e;
      step();
    end
    check("default_rdy_seen", int'(done), 1);
    check("default_latency", d_rdy - a, D_L);
    check("default_e_pulses", rises, 2);
    check("default_e_width", w1, D_PW);
    check("default_setup", first_rise - a, 2);
    check("default_nib_hi", int'(dnib[0]), 0);
    check("default_nib_lo", int'(dnib[1]), 1);
    check("default_rs", int'(d_rs), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
